// File: rtl/hdmi_tx_cfg_seq_pkg.sv
// Shared types and the default register table for the HDMI transmitter
// configuration sequencer (1080p60, RGB888 input, HDMI output mode).
package hdmi_cfg_pkg;

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_SETTLE,
    ST_WRITE,
    ST_GAP,
    ST_BACKOFF,
    ST_DONE,
    ST_ERR
  } cfg_state_t;

  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] dat;
  } cfg_entry_t;

  localparam int CFG_TABLE_LEN = 8;

  // Power-up, fixed registers, RGB888 input style, HDMI (not DVI) output.
  localparam cfg_entry_t CFG_TABLE_1080P [CFG_TABLE_LEN] = '{
    '{8'h41, 8'h10},
    '{8'h98, 8'h03},
    '{8'h9A, 8'hE0},
    '{8'h9C, 8'h30},
    '{8'h9D, 8'h61},
    '{8'h15, 8'h00},
    '{8'h16, 8'h30},
    '{8'hAF, 8'h06}
  };

  function automatic int clog2_min1(input int value);
    return ($clog2(value) < 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/hdmi_tx_cfg_seq_if.sv
// Byte-level I2C write request/response bundle between the sequencer and
// the I2C write master.
interface hdmi_tx_cfg_seq_if;

  logic       i2c_req;
  logic [6:0] i2c_dev;
  logic [7:0] i2c_reg;
  logic [7:0] i2c_dat;
  logic       i2c_done;
  logic       i2c_nack;

  modport master (
    output i2c_req,
    output i2c_dev,
    output i2c_reg,
    output i2c_dat,
    input  i2c_done,
    input  i2c_nack
  );

  modport slave (
    input  i2c_req,
    input  i2c_dev,
    input  i2c_reg,
    input  i2c_dat,
    output i2c_done,
    output i2c_nack
  );

endinterface

// File: rtl/hdmi_tx_cfg_seq_rom.sv
// Combinational lookup into the default configuration table; indices at or
// beyond REG_NUM read as zero.
module hdmi_cfg_rom
  import hdmi_cfg_pkg::*;
#(
  parameter int REG_NUM = 8,
  parameter int IDX_W   = clog2_min1(REG_NUM)
) (
  input  logic [IDX_W-1:0] idx,
  output cfg_entry_t       entry
);

  always_comb begin
    entry = '0;
    for (int i = 0; i < CFG_TABLE_LEN; i++) begin
      if (int'(idx) == i && i < REG_NUM) begin
        entry = CFG_TABLE_1080P[i];
      end
    end
  end

endmodule

// File: rtl/hdmi_tx_cfg_seq.sv
// Power-up and register-table sequencer for the HDMI transmitter: reset hold,
// settle delay, then table writes over I2C with NACK retry and backoff.
module hdmi_tx_cfg_seq
  import hdmi_cfg_pkg::*;
#(
  parameter int         RST_HOLD_CYC = 10000,
  parameter int         SETTLE_CYC   = 2000,
  parameter int         BACKOFF_CYC  = 64,
  parameter int         MAX_RETRY    = 3,
  parameter int         REG_NUM      = 8,
  parameter logic [6:0] DEV_ADDR     = 7'h3B
) (
  input  logic               cfg_clk,
  input  logic               rst,
  input  logic               start,
  output logic               rstn_out,
  output logic               init_over,
  output logic               cfg_err,
  output logic               led_int,
  hdmi_tx_cfg_seq_if.master  i2c
);

  localparam int MAX_HS  = (RST_HOLD_CYC > SETTLE_CYC) ? RST_HOLD_CYC : SETTLE_CYC;
  localparam int MAX_CYC = (MAX_HS > BACKOFF_CYC) ? MAX_HS : BACKOFF_CYC;
  localparam int CNT_W   = clog2_min1(MAX_CYC);
  localparam int IDX_W   = clog2_min1(REG_NUM);
  localparam int RTY_W   = clog2_min1(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] BACKOFF_LAST = CNT_W'(BACKOFF_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(REG_NUM - 1);
  localparam logic [RTY_W-1:0] RTY_LAST     = RTY_W'(MAX_RETRY);

  cfg_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [RTY_W-1:0] retry, retry_nxt;
  cfg_entry_t       rom_entry;

  // The ROM is addressed with the next index so the registered reg/dat
  // bytes change on the same edge that raises i2c_req.
  hdmi_cfg_rom #(
    .REG_NUM (REG_NUM),
    .IDX_W   (IDX_W)
  ) u_rom (
    .idx   (idx_nxt),
    .entry (rom_entry)
  );

  assign i2c.i2c_dev = DEV_ADDR;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    retry_nxt = retry;
    case (state)
      ST_HOLD: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == HOLD_LAST) state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == SETTLE_LAST) state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        if (i2c.i2c_done) begin
          if (!i2c.i2c_nack) begin
            retry_nxt = '0;
            if (idx == IDX_LAST) begin
              state_nxt = ST_DONE;
            end else begin
              idx_nxt   = idx + 1'b1;
              state_nxt = ST_GAP;
            end
          end else if (retry == RTY_LAST) begin
            state_nxt = ST_ERR;
          end else begin
            retry_nxt = retry + 1'b1;
            state_nxt = ST_BACKOFF;
          end
        end
      end
      ST_GAP: state_nxt = ST_WRITE;
      ST_BACKOFF: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == BACKOFF_LAST) state_nxt = ST_WRITE;
      end
      ST_DONE, ST_ERR: begin
        if (start) begin
          state_nxt = ST_HOLD;
          idx_nxt   = '0;
          retry_nxt = '0;
        end
      end
      default: state_nxt = ST_HOLD;
    endcase
    if (state_nxt != state) cnt_nxt = '0;
  end

  // Outputs are decoded from the next state so they are true registers.
  always_ff @(posedge cfg_clk) begin
    if (rst) begin
      state       <= ST_HOLD;
      cnt         <= '0;
      idx         <= '0;
      retry       <= '0;
      rstn_out    <= 1'b0;
      i2c.i2c_req <= 1'b0;
      i2c.i2c_reg <= '0;
      i2c.i2c_dat <= '0;
      init_over   <= 1'b0;
      cfg_err     <= 1'b0;
      led_int     <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      idx         <= idx_nxt;
      retry       <= retry_nxt;
      rstn_out    <= (state_nxt != ST_HOLD);
      i2c.i2c_req <= (state_nxt == ST_WRITE);
      i2c.i2c_reg <= rom_entry.reg_addr;
      i2c.i2c_dat <= rom_entry.dat;
      init_over   <= (state_nxt == ST_DONE);
      cfg_err     <= (state_nxt == ST_ERR);
      led_int     <= (state_nxt == ST_DONE);
    end
  end

endmodule

// File: tb/tb_hdmi_tx_cfg_seq.sv
// Directed bench for hdmi_tx_cfg_seq with a small I2C master model that
// answers each request five cycles after it first appears.
module tb_hdmi_tx_cfg_seq;

  localparam int         RST_HOLD   = 20;
  localparam int         SETTLE     = 10;
  localparam int         BACKOFF    = 4;
  localparam int         MAX_RETRY  = 2;
  localparam int         REG_NUM    = 4;
  localparam logic [6:0] DEV        = 7'h3B;
  localparam int         DONE_DELAY = 5;
  localparam int         WAIT_LIMIT = 200;

  logic cfg_clk = 1'b0;
  logic rst     = 1'b1;
  logic start   = 1'b0;
  logic rstn_out, init_over, cfg_err, led_int;

  hdmi_tx_cfg_seq_if i2c ();

  logic [7:0] expReg [REG_NUM] = '{8'h41, 8'h98, 8'h9A, 8'h9C};
  logic [7:0] expDat [REG_NUM] = '{8'h10, 8'h03, 8'hE0, 8'h30};

  int cyc        = 0;
  int checkCount = 0;
  int passCount  = 0;

  hdmi_tx_cfg_seq #(
    .RST_HOLD_CYC (RST_HOLD),
    .SETTLE_CYC   (SETTLE),
    .BACKOFF_CYC  (BACKOFF),
    .MAX_RETRY    (MAX_RETRY),
    .REG_NUM      (REG_NUM),
    .DEV_ADDR     (DEV)
  ) dut (
    .cfg_clk   (cfg_clk),
    .rst       (rst),
    .start     (start),
    .rstn_out  (rstn_out),
    .init_over (init_over),
    .cfg_err   (cfg_err),
    .led_int   (led_int),
    .i2c       (i2c)
  );

  always #5 cfg_clk = ~cfg_clk;

  task automatic step();
    @(posedge cfg_clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
  endtask

  task automatic waitReq(input string tag, output int seenCyc);
    int n = 0;
    while (i2c.i2c_req !== 1'b1 && n < WAIT_LIMIT) begin
      step();
      n++;
    end
    checkOutput($sformatf("%s req seen", tag), 32'(i2c.i2c_req), 32'd1);
    seenCyc = cyc;
  endtask

  // One I2C transaction: wait for the request, check the entry, answer after
  // DONE_DELAY cycles, and confirm the request drops on the following cycle.
  task automatic applyStimulus(input string tag, input int entry, input logic nack,
                               output int reqCyc, output int doneCyc);
    waitReq(tag, reqCyc);
    checkOutput($sformatf("%s reg", tag), 32'(i2c.i2c_reg), 32'(expReg[entry]));
    checkOutput($sformatf("%s dat", tag), 32'(i2c.i2c_dat), 32'(expDat[entry]));
    repeat (DONE_DELAY) step();
    checkOutput($sformatf("%s reg stable", tag), 32'(i2c.i2c_reg), 32'(expReg[entry]));
    i2c.i2c_done = 1'b1;
    i2c.i2c_nack = nack;
    doneCyc = cyc;
    step();
    i2c.i2c_done = 1'b0;
    i2c.i2c_nack = 1'b0;
    checkOutput($sformatf("%s req drops", tag), 32'(i2c.i2c_req), 32'd0);
  endtask

  task automatic checkPowerUp(input string tag, input int startCyc, input bit pokeStart);
    int n = 0;
    while (rstn_out !== 1'b1 && n < WAIT_LIMIT) begin
      step();
      n++;
    end
    checkOutput($sformatf("%s rstn rise", tag), 32'(cyc - startCyc), 32'(RST_HOLD));
    if (pokeStart) begin
      start = 1'b1;
      step();
      start = 1'b0;
    end
    n = 0;
    while (i2c.i2c_req !== 1'b1 && n < WAIT_LIMIT) begin
      step();
      n++;
    end
    checkOutput($sformatf("%s req rise", tag), 32'(cyc - startCyc), 32'(RST_HOLD + SETTLE));
    checkOutput($sformatf("%s rstn held", tag), 32'(rstn_out), 32'd1);
    checkOutput($sformatf("%s entry0 reg", tag), 32'(i2c.i2c_reg), 32'(expReg[0]));
    checkOutput($sformatf("%s entry0 dat", tag), 32'(i2c.i2c_dat), 32'(expDat[0]));
  endtask

  task automatic pulseStart(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    checkOutput($sformatf("%s rstn low", tag), 32'(rstn_out), 32'd0);
    checkOutput($sformatf("%s init cleared", tag), 32'(init_over), 32'd0);
    checkOutput($sformatf("%s err cleared", tag), 32'(cfg_err), 32'd0);
  endtask

  initial begin
    int reqC, doneC, prevDone, nackDone, reqSeen, mark;
    i2c.i2c_done = 1'b0;
    i2c.i2c_nack = 1'b0;

    repeat (3) step();
    checkOutput("reset rstn", 32'(rstn_out), 32'd0);
    checkOutput("reset req", 32'(i2c.i2c_req), 32'd0);
    checkOutput("reset init", 32'(init_over), 32'd0);
    checkOutput("reset err", 32'(cfg_err), 32'd0);
    checkOutput("reset led", 32'(led_int), 32'd0);
    checkOutput("dev addr", 32'(i2c.i2c_dev), 32'(DEV));

    // Power-up with an ignored start pulse during the settle window.
    rst = 1'b0;
    cyc = 0;
    checkPowerUp("power-up", 0, 1'b1);

    $display("[TB] all-ACK table write");
    prevDone = 0;
    for (int e = 0; e < REG_NUM; e++) begin
      applyStimulus($sformatf("ack e%0d", e), e, 1'b0, reqC, doneC);
      if (e > 0) checkOutput($sformatf("ack e%0d gap", e), 32'(reqC - prevDone), 32'd2);
      prevDone = doneC;
    end
    checkOutput("ack init_over", 32'(init_over), 32'd1);
    checkOutput("ack led_int", 32'(led_int), 32'd1);
    checkOutput("ack cfg_err", 32'(cfg_err), 32'd0);
    repeat (5) step();
    checkOutput("done idle req", 32'(i2c.i2c_req), 32'd0);
    checkOutput("done holds init", 32'(init_over), 32'd1);

    $display("[TB] restart from DONE, single NACK on entry 2");
    pulseStart("restart done");
    checkPowerUp("restart done", cyc, 1'b0);
    applyStimulus("nack1 e0", 0, 1'b0, reqC, doneC);
    applyStimulus("nack1 e1", 1, 1'b0, reqC, doneC);
    applyStimulus("nack1 e2", 2, 1'b1, reqC, nackDone);
    repeat (BACKOFF - 1) begin
      step();
      checkOutput("backoff req low", 32'(i2c.i2c_req), 32'd0);
    end
    applyStimulus("retry e2", 2, 1'b0, reqC, doneC);
    checkOutput("retry latency", 32'(reqC - nackDone), 32'(BACKOFF + 1));
    applyStimulus("nack1 e3", 3, 1'b0, reqC, doneC);
    checkOutput("nack1 init_over", 32'(init_over), 32'd1);
    checkOutput("nack1 cfg_err", 32'(cfg_err), 32'd0);

    $display("[TB] retries exhausted on entry 1");
    pulseStart("restart done2");
    checkPowerUp("restart done2", cyc, 1'b0);
    applyStimulus("exh e0", 0, 1'b0, reqC, doneC);
    for (int r = 0; r <= MAX_RETRY; r++) begin
      applyStimulus($sformatf("exh e1 try%0d", r), 1, 1'b1, reqC, doneC);
    end
    checkOutput("exh cfg_err", 32'(cfg_err), 32'd1);
    checkOutput("exh init_over", 32'(init_over), 32'd0);
    checkOutput("exh led_int", 32'(led_int), 32'd0);
    reqSeen = 0;
    repeat (20) begin
      step();
      if (i2c.i2c_req !== 1'b0) reqSeen++;
    end
    checkOutput("exh no further req", 32'(reqSeen), 32'd0);
    checkOutput("exh err held", 32'(cfg_err), 32'd1);

    $display("[TB] restart from ERR, then reset mid-write of entry 1");
    pulseStart("restart err");
    checkPowerUp("restart err", cyc, 1'b0);
    applyStimulus("rst e0", 0, 1'b0, reqC, doneC);
    waitReq("rst e1", reqC);
    repeat (2) step();
    rst = 1'b1;
    step();
    checkOutput("midrst rstn", 32'(rstn_out), 32'd0);
    checkOutput("midrst req", 32'(i2c.i2c_req), 32'd0);
    checkOutput("midrst init", 32'(init_over), 32'd0);
    checkOutput("midrst err", 32'(cfg_err), 32'd0);
    checkOutput("midrst led", 32'(led_int), 32'd0);
    rst = 1'b0;
    mark = cyc;
    i2c.i2c_done = 1'b1;
    step();
    i2c.i2c_done = 1'b0;
    checkPowerUp("after rst", mark, 1'b0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
